s4_test_checker: RTL
====================

# s4_test_checker

Synthesizable self-check stage downstream of the s4 RV64I core. It consumes the core's register-file taps:
- x11 as the check strobe,
- x30 as the expected value,
- x31 as the actual value,
- the PC.

Per test it counts passes and failures, queues failure records for a host or debug reader over a valid/ready stream, and flags end-of-program when the PC stops advancing.

## Interface
Parameters:
- CNT_W, 16, width of the pass/fail counters (saturating)
- FIFO_DEPTH, 4, failure-record queue depth; power of two, ≥2
- STALL_LIMIT, 64, consecutive cycles of unchanged PC that declare end-of-program; ≥2

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- iflag  in  1  check strobe (core x11 == 1)
- iexp  in  64  expected value (core x30)
- iact  in  64  actual value (core x31)
- ipc  in  32  core program counter
- opass_cnt  out  CNT_W  passed checks
- ofail_cnt  out  CNT_W  failed checks
- odone  out  1  end-of-program detected (sticky)
- oall_pass  out  1  odone & ofail_cnt==0 & opass_cnt!=0
- ooverflow  out  1  sticky: failure record dropped, queue full
- ovalid  out  1  failure record available
- iready  in  1  reader accepts record
- orec_pc  out  32  PC of failing check
- orec_exp  out  64  expected value of failing check
- orec_act  out  64  actual value of failing check

## Operation
- **Event detection**
  - flag_q registers iflag every cycle.
  - Check event = iflag & ~flag_q & ~odone. The rising edge counts once, however long x11 stays high.
- **Compare**
  - On an event, iexp == iact (full 64-bit, unsigned) is a pass; anything else is a fail.
- **Pass**
  - opass_cnt += 1; saturates at 2^CNT_W−1.
- **Fail**
  - ofail_cnt += 1, with the same saturation.
  - Push {ipc, iexp, iact}, sampled in the event cycle.
  - If the queue is full and no pop occurs that cycle, drop the record and set ooverflow.
- **Queue**
  - Circular buffer with read/write pointers and an occupancy count 0..FIFO_DEPTH.
  - ovalid = count != 0.
  - orec_* presents the head entry. It is don't-care when ovalid=0 and holds stable while ovalid & ~iready.
  - Pop when ovalid & iready.
  - Push and pop in the same cycle: both are performed and the count is unchanged. When full, this push is accepted and ooverflow is not set.
- **End detection**
  - pc_q registers ipc every cycle.
  - stall_cnt increments, saturating at STALL_LIMIT, when ipc == pc_q; otherwise it clears to 0.
  - odone sets when stall_cnt reaches STALL_LIMIT and stays set until reset.
  - After odone, events are ignored. The queue continues to drain.
- **Reset**, applied synchronously in any state including mid-drain:
  - counters 0, queue empty (ovalid 0), ooverflow 0, odone 0, oall_pass 0;
  - flag_q 0, pc_q 0, stall_cnt 0.

## Timing
- All outputs are registered or decoded directly from registers. There is no combinational path from the inputs to any output.
- A high iflag in the first cycle after reset deassertion counts as an event (flag_q resets to 0).
- Latency:
  - Event in cycle N → counter updated at the edge ending cycle N, visible in cycle N+1.
  - Failure record visible on ovalid in cycle N+1 if the queue was empty.
- Stall timing:
  - With ipc held constant from cycle M, ipc == pc_q first in cycle M+1.
  - odone rises in cycle M+STALL_LIMIT+1.
  - Any PC change restarts the count.
- Events in consecutive cycles are impossible, since each needs a 0→1 edge. At most one push per two cycles.
- An event coinciding with odone setting in the same cycle is still counted. Events are gated by the registered odone.

## Test plan
- Reset, then three pulses on iflag with iexp=iact=0x5A, 0x0, 0xFFFF_FFFF_FFFF_FFFF; hold ipc=0x100 → opass_cnt=3, ofail_cnt=0, ovalid=0; odone rises STALL_LIMIT+1 cycles after ipc settles; oall_pass=1.
- iflag held high 10 cycles, iexp=1, iact=2, ipc=0x24 → ofail_cnt=1 only; one record with orec_pc=0x24, orec_exp=1, orec_act=2 on ovalid the next cycle.
- iready=0, 5 failures (FIFO_DEPTH=4) → ovalid=1, ooverflow=1 after the 5th; drain with iready=1 → exactly 4 records in event order, then ovalid=0.
- Queue full, 4th pop and a new failure in the same cycle → no overflow; count stays 4; new record is last out.
- Reset asserted for 1 cycle mid-drain with 2 records queued and counts 7/2 → next cycle ovalid=0, counts 0, ooverflow=0, odone=0.
- ipc toggling every STALL_LIMIT−1 cycles → odone stays 0; after odone=1, an iflag pulse with iexp≠iact → ofail_cnt unchanged, no push.

Source files
------------

// File: rtl/s4_test_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : s4_test_checker_if
// Description : Failure-record valid/ready stream of the s4 self-check stage.
// Revision    : 1.0
// ============================================================================
interface s4_test_checker_if;
  logic        ovalid;
  logic        iready;
  logic [31:0] orec_pc;
  logic [63:0] orec_exp;
  logic [63:0] orec_act;

  modport master (
    output ovalid,
    output orec_pc,
    output orec_exp,
    output orec_act,
    input  iready
  );

  modport slave (
    input  ovalid,
    input  orec_pc,
    input  orec_exp,
    input  orec_act,
    output iready
  );
endinterface
`default_nettype wire

// File: rtl/s4_test_checker.sv
`default_nettype none
// ============================================================================
// Module      : s4_test_checker
// Description : Counts pass/fail checks from s4 core register taps, queues
//               failure records, and detects end-of-program by PC stall.
// Revision    : 1.0
// ============================================================================
module s4_test_checker #(
  parameter int CNT_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_LIMIT = 64
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             iflag,
  input  wire logic [63:0]      iexp,
  input  wire logic [63:0]      iact,
  input  wire logic [31:0]      ipc,
  output logic      [CNT_W-1:0] opass_cnt,
  output logic      [CNT_W-1:0] ofail_cnt,
  output logic                  odone,
  output logic                  oall_pass,
  output logic                  ooverflow,
  s4_test_checker_if.master     rec
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(FIFO_DEPTH + 1);
  localparam int c_SW = $clog2(STALL_LIMIT + 1);

  localparam logic [c_CW-1:0]  c_FULL   = c_CW'(FIFO_DEPTH);
  localparam logic [c_SW-1:0]  c_STALL  = c_SW'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] c_CNTMAX = {CNT_W{1'b1}};

  logic              r_flag_q;
  logic [31:0]       r_pc_q;
  logic [c_SW-1:0]   r_stall;
  logic              r_done;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_pass;
  logic [CNT_W-1:0]  r_fail;
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_CW-1:0]   r_count;
  logic [159:0]      r_mem [FIFO_DEPTH];

  logic              w_event;
  logic              w_match;
  logic              w_pop;
  logic              w_full;
  logic              w_push_req;
  logic              w_push;
  logic [c_SW-1:0]   w_stall_next;
  logic [159:0]      w_head;

  // Only a 0->1 edge of the strobe is a check; the registered done gates it.
  assign w_event    = iflag & ~r_flag_q & ~r_done;
  assign w_match    = (iexp == iact);
  assign w_pop      = (r_count != '0) & rec.iready;
  assign w_full     = (r_count == c_FULL);
  assign w_push_req = w_event & ~w_match;
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_comb begin
    w_stall_next = '0;
    if (ipc == r_pc_q) begin
      w_stall_next = (r_stall == c_STALL) ? r_stall : r_stall + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_flag_q <= 1'b0;
      r_pc_q   <= '0;
      r_stall  <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_pass   <= '0;
      r_fail   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_flag_q <= iflag;
      r_pc_q   <= ipc;
      r_stall  <= w_stall_next;
      // Deciding on the next stall value lets done rise the cycle it saturates.
      r_done   <= r_done | (w_stall_next == c_STALL);

      if (w_event && w_match && (r_pass != c_CNTMAX)) begin
        r_pass <= r_pass + 1'b1;
      end
      if (w_push_req && (r_fail != c_CNTMAX)) begin
        r_fail <= r_fail + 1'b1;
      end
      if (w_push_req && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end

      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: the occupancy count alone defines validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= {ipc, iexp, iact};
    end
  end

  assign w_head = r_mem[r_rptr];

  assign opass_cnt    = r_pass;
  assign ofail_cnt    = r_fail;
  assign odone        = r_done;
  assign ooverflow    = r_ovf;
  assign oall_pass    = r_done & (r_fail == '0) & (r_pass != '0);
  assign rec.ovalid   = (r_count != '0);
  assign rec.orec_pc  = w_head[159:128];
  assign rec.orec_exp = w_head[127:64];
  assign rec.orec_act = w_head[63:0];

endmodule
`default_nettype wire
